spi_pwm_bank: RTL and testbench

Multi-channel successor to the single-LED SPI PWM path. Receives a byte stream from the existing spi block in the sysclk domain and decodes it as an addressed register write burst. Drives CHANNELS independent PWM outputs, for example the RGB0/1/2PWM inputs of SB_RGBA_DRV. Adds frame-atomic commit, glitch-free period-boundary updates, a global enable and linear fading toward target duty.

---
 rtl/spi_pwm_bank.sv | 211 +++++++++++++++++++++
 tb/tb_spi_pwm_bank.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_pwm_bank.sv
// spi_pwm_bank: turns an addressed SPI write burst into CHANNELS PWM outputs.
// Each frame stages its bytes into shadow registers, and the shadows are
// copied to the live registers in one step when the frame ends. Duty changes
// only take effect at period boundaries, so an output never changes duty in
// the middle of a period. Duty can optionally fade linearly toward its target.
module spi_pwm_bank #(
  parameter int CHANNELS = 3,
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 4
) (
  input  logic                sysclk,
  input  logic                rst_n,
  input  logic [7:0]          spi_dout,
  input  logic                spi_drdy,
  input  logic                spi_cs_falling,
  input  logic                spi_cs_rising,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                frame_err
);

  localparam int              PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [7:0]      CTRL_ADDR  = 8'(CHANNELS);
  localparam logic [7:0]      DIV_ADDR   = 8'(CHANNELS + 1);
  localparam logic [WIDTH-1:0] DUTY_MAX  = '1;

  // Frame decode: idle, waiting for the address byte, or receiving data bytes.
  typedef enum logic [1:0] {
    FR_IDLE,
    FR_ADDR,
    FR_DATA
  } frame_state_t;

  // Frame decode state
  frame_state_t frame_q, frame_d;
  logic [7:0]   ptr_q, ptr_d;
  logic         dirty_q, dirty_d;
  logic         perr_q, perr_d;

  // Shadow registers, written byte by byte during a frame
  logic [CHANNELS-1:0][WIDTH-1:0] sh_duty_q, sh_duty_d;
  logic [1:0]                     sh_ctrl_q, sh_ctrl_d;
  logic [7:0]                     sh_div_q, sh_div_d;

  // Live registers, updated together at commit
  logic [CHANNELS-1:0][WIDTH-1:0] target_q, target_d;
  logic                           enable_q, enable_d;
  logic                           fade_en_q, fade_en_d;
  logic [7:0]                     fade_div_q, fade_div_d;
  logic                           frame_err_q, frame_err_d;

  // PWM timebase and per-channel current duty
  logic [PW-1:0]                  presc_q, presc_d;
  logic [WIDTH-1:0]               cnt_q, cnt_d;
  logic [7:0]                     fade_cnt_q, fade_cnt_d;
  logic [CHANNELS-1:0][WIDTH-1:0] cur_q, cur_d;
  logic [CHANNELS-1:0]            pwm_q, pwm_d;

  logic       commit;
  logic       tick;
  logic       boundary;
  logic [7:0] fade_next;

  // Decode the byte stream into shadow writes and detect a committing frame end.
  // NOTE: every signal assigned in an always_comb gets a default first so no latch is inferred.
  always_comb begin
    frame_d   = frame_q;
    ptr_d     = ptr_q;
    dirty_d   = dirty_q;
    perr_d    = perr_q;
    sh_duty_d = sh_duty_q;
    sh_ctrl_d = sh_ctrl_q;
    sh_div_d  = sh_div_q;
    commit    = 1'b0;

    if (spi_cs_falling) begin
      // A new frame start also restarts a frame already in progress; shadows stay.
      frame_d = FR_ADDR;
      dirty_d = 1'b0;
      perr_d  = 1'b0;
    end else if (frame_q != FR_IDLE) begin
      if (spi_drdy) begin
        if (frame_q == FR_ADDR) begin
          ptr_d   = spi_dout;
          frame_d = FR_DATA;
        end else begin
          dirty_d = 1'b1;
          ptr_d   = ptr_q + 8'd1;
          if (ptr_q == CTRL_ADDR) begin
            sh_ctrl_d = spi_dout[1:0];
          end else if (ptr_q == DIV_ADDR) begin
            sh_div_d = spi_dout;
          end else if (ptr_q < CTRL_ADDR) begin
            for (int i = 0; i < CHANNELS; i++) begin
              if (ptr_q == 8'(i)) sh_duty_d[i] = spi_dout[WIDTH-1:0];
            end
          end else begin
            perr_d = 1'b1;
          end
        end
      end
      // A byte arriving together with the frame end is already in the *_d values.
      if (spi_cs_rising) begin
        frame_d = FR_IDLE;
        commit  = dirty_d;
      end
    end
  end

  // Copy all shadows to the live registers in the same cycle when a frame commits.
  always_comb begin
    target_d    = target_q;
    enable_d    = enable_q;
    fade_en_d   = fade_en_q;
    fade_div_d  = fade_div_q;
    frame_err_d = frame_err_q;
    if (commit) begin
      target_d    = sh_duty_d;
      enable_d    = sh_ctrl_d[0];
      fade_en_d   = sh_ctrl_d[1];
      fade_div_d  = sh_div_d;
      frame_err_d = perr_d;
    end
  end

  // Advance the timebase, update current duty at period boundaries, and form the outputs.
  always_comb begin
    tick      = (presc_q == PRESC_LAST);
    presc_d   = tick ? '0 : presc_q + PW'(1);
    cnt_d     = tick ? cnt_q + WIDTH'(1) : cnt_q;
    boundary  = tick && (cnt_q == DUTY_MAX);
    fade_next = fade_cnt_q + 8'd1;
    cur_d     = cur_q;
    fade_cnt_d = fade_cnt_q;

    if (boundary) begin
      if (!fade_en_q || (fade_div_q == 8'd0)) begin
        cur_d      = target_q;
        fade_cnt_d = 8'd0;
      end else if (fade_next == fade_div_q) begin
        fade_cnt_d = 8'd0;
        for (int i = 0; i < CHANNELS; i++) begin
          if (cur_q[i] < target_q[i]) begin
            cur_d[i] = cur_q[i] + WIDTH'(1);
          end else if (cur_q[i] > target_q[i]) begin
            cur_d[i] = cur_q[i] - WIDTH'(1);
          end
        end
      end else begin
        fade_cnt_d = fade_next;
      end
    end

    // All-zero and all-ones duties are forced so they never produce a one-cycle glitch.
    for (int i = 0; i < CHANNELS; i++) begin
      if (!enable_q || (cur_q[i] == '0)) begin
        pwm_d[i] = 1'b0;
      end else if (cur_q[i] == DUTY_MAX) begin
        pwm_d[i] = 1'b1;
      end else begin
        pwm_d[i] = (cnt_q < cur_q[i]);
      end
    end
  end

  // State registers; the shadows are a handful of flops and take the reset like the rest.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q     <= FR_IDLE;
      ptr_q       <= 8'd0;
      dirty_q     <= 1'b0;
      perr_q      <= 1'b0;
      sh_duty_q   <= '0;
      sh_ctrl_q   <= 2'd0;
      sh_div_q    <= 8'd0;
      target_q    <= '0;
      enable_q    <= 1'b0;
      fade_en_q   <= 1'b0;
      fade_div_q  <= 8'd0;
      frame_err_q <= 1'b0;
      presc_q     <= '0;
      cnt_q       <= '0;
      fade_cnt_q  <= 8'd0;
      cur_q       <= '0;
      pwm_q       <= '0;
    end else begin
      frame_q     <= frame_d;
      ptr_q       <= ptr_d;
      dirty_q     <= dirty_d;
      perr_q      <= perr_d;
      sh_duty_q   <= sh_duty_d;
      sh_ctrl_q   <= sh_ctrl_d;
      sh_div_q    <= sh_div_d;
      target_q    <= target_d;
      enable_q    <= enable_d;
      fade_en_q   <= fade_en_d;
      fade_div_q  <= fade_div_d;
      frame_err_q <= frame_err_d;
      presc_q     <= presc_d;
      cnt_q       <= cnt_d;
      fade_cnt_q  <= fade_cnt_d;
      cur_q       <= cur_d;
      pwm_q       <= pwm_d;
    end
  end

  assign pwm_out   = pwm_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_pwm_bank.sv
// Testbench for spi_pwm_bank: directed frames plus randomized gaps, stray
// strobes and random frames, checked every cycle against a byte-level model.
module tb_spi_pwm_bank;

  localparam int CH     = 3;
  localparam int W      = 8;
  localparam int P      = 1;
  localparam int MAXV   = (1 << W) - 1;
  localparam int NREG   = CH + 2;
  localparam int PERIOD = P * (1 << W);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    spi_dout;
  logic          spi_drdy;
  logic          spi_cs_falling;
  logic          spi_cs_rising;
  logic [CH-1:0] pwm_out;
  logic          frame_err;

  int checks = 0;
  int errors = 0;

  // Reference model: register file contents, live settings and the cycle count since reset.
  int unsigned t_m;
  int          shadow_m [NREG];
  int          tgt_m [CH];
  int          cur_m [CH];
  bit          en_m, fade_m, err_m;
  int          div_m, fcnt_m;
  bit          pend_commit, pend_err;
  logic [7:0]  fb [$];

  spi_pwm_bank #(.CHANNELS(CH), .WIDTH(W), .PRESCALE(P)) dut (
    .sysclk         (clk),
    .rst_n          (rst_n),
    .spi_dout       (spi_dout),
    .spi_drdy       (spi_drdy),
    .spi_cs_falling (spi_cs_falling),
    .spi_cs_rising  (spi_cs_rising),
    .pwm_out        (pwm_out),
    .frame_err      (frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    t_m = 0;
    for (int i = 0; i < NREG; i++) shadow_m[i] = 0;
    for (int i = 0; i < CH; i++) begin
      tgt_m[i] = 0;
      cur_m[i] = 0;
    end
    en_m = 0; fade_m = 0; err_m = 0; div_m = 0; fcnt_m = 0;
    pend_commit = 0; pend_err = 0;
  endtask

  function automatic bit pwm_ref(input bit en, input int duty, input int cnt);
    if (!en || duty == 0) return 1'b0;
    if (duty == MAXV) return 1'b1;
    return (cnt < duty);
  endfunction

  // One period has just ended: move current duties according to the fade rules.
  task automatic period_end();
    if (!fade_m || div_m == 0) begin
      for (int i = 0; i < CH; i++) cur_m[i] = tgt_m[i];
      fcnt_m = 0;
    end else begin
      fcnt_m = (fcnt_m + 1) % 256;
      if (fcnt_m == div_m) begin
        fcnt_m = 0;
        for (int i = 0; i < CH; i++) begin
          if (cur_m[i] < tgt_m[i]) cur_m[i]++;
          else if (cur_m[i] > tgt_m[i]) cur_m[i]--;
        end
      end
    end
  endtask

  // Drive one cycle of inputs, advance the model across the edge, compare outputs.
  task automatic step(input bit fall, input bit drdy, input logic [7:0] dout, input bit rise);
    logic [CH-1:0] exp;
    int            cnt;
    spi_cs_falling = fall;
    spi_drdy       = drdy;
    spi_dout       = dout;
    spi_cs_rising  = rise;
    @(posedge clk);
    cnt = int'((t_m / P) % (1 << W));
    for (int i = 0; i < CH; i++) exp[i] = pwm_ref(en_m, cur_m[i], cnt);
    t_m++;
    if (t_m % PERIOD == 0) period_end();
    if (rise && pend_commit) begin
      for (int i = 0; i < CH; i++) tgt_m[i] = shadow_m[i] & MAXV;
      en_m   = (shadow_m[CH] & 1) != 0;
      fade_m = (shadow_m[CH] & 2) != 0;
      div_m  = shadow_m[CH+1] & 255;
      err_m  = pend_err;
    end
    if (rise) pend_commit = 0;
    #1;
    check("pwm_out", 32'(pwm_out), 32'(exp));
    check("frame_err", 32'(frame_err), 32'(err_m));
    spi_cs_falling = 1'b0;
    spi_drdy       = 1'b0;
    spi_cs_rising  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 8'($urandom), 1'b0);
  endtask

  // Send the bytes in fb as one frame with random gaps; optionally end it.
  task automatic send_frame(input bit do_rise);
    int ptr;
    bit dirty, perr, merge;
    ptr = 0; dirty = 0; perr = 0; merge = 0;
    step(1'b1, 1'b0, 8'd0, 1'b0);
    for (int i = 0; i < fb.size(); i++) begin
      idle($urandom_range(0, 3));
      if (i == 0) begin
        ptr = int'(fb[0]);
      end else begin
        if (ptr < NREG) shadow_m[ptr] = int'(fb[i]);
        else perr = 1;
        dirty = 1;
        ptr = (ptr + 1) % 256;
      end
      merge = do_rise && (i == fb.size() - 1) && ($urandom_range(0, 1) == 1);
      if (merge) begin
        pend_commit = dirty;
        pend_err    = perr;
      end
      step(1'b0, 1'b1, fb[i], merge);
    end
    if (do_rise && !merge) begin
      idle($urandom_range(0, 3));
      pend_commit = dirty;
      pend_err    = perr;
      step(1'b0, 1'b0, 8'd0, 1'b1);
    end
  endtask

  // Count high cycles per channel over one full period-length window.
  task automatic measure(input string tag, input int e0, input int e1, input int e2);
    int c [CH];
    int e [CH];
    e[0] = e0; e[1] = e1; e[2] = e2;
    for (int i = 0; i < CH; i++) c[i] = 0;
    for (int k = 0; k < PERIOD; k++) begin
      step(1'b0, 1'b0, 8'd0, 1'b0);
      for (int i = 0; i < CH; i++) c[i] += int'(pwm_out[i]);
    end
    for (int i = 0; i < CH; i++) check($sformatf("%s_ch%0d", tag, i), 32'(c[i]), 32'(e[i]));
  endtask

  task automatic settle();
    idle(2 * PERIOD + 4);
  endtask

  initial begin
    rst_n = 1'b0;
    spi_dout = 8'd0; spi_drdy = 1'b0; spi_cs_falling = 1'b0; spi_cs_rising = 1'b0;
    reset_model();
    repeat (3) @(posedge clk);
    #2;
    check("reset_pwm", 32'(pwm_out), 32'd0);
    check("reset_err", 32'(frame_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Stray strobes outside a frame do nothing.
    step(1'b0, 1'b1, 8'h55, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1);

    // Basic frame: three duties and control.
    fb = '{8'h00, 8'h80, 8'h40, 8'h00, 8'h03};
    send_frame(1'b1);
    settle();
    measure("basic", 128, 64, 0);

    // Full-on and full-off.
    fb = '{8'h00, 8'hFF, 8'h00};
    send_frame(1'b1);
    settle();
    measure("full", 256, 0, 0);

    // Mid-period duty change.
    fb = '{8'h00, 8'h80};
    send_frame(1'b1);
    settle();
    idle($urandom_range(10, 200));
    fb = '{8'h00, 8'h10};
    send_frame(1'b1);
    settle();
    measure("midchg", 16, 0, 0);

    // Fade: enable + fade_en, divider 2, then ch0 target 0.
    fb = '{8'h03, 8'h03, 8'h02};
    send_frame(1'b1);
    fb = '{8'h00, 8'h00};
    send_frame(1'b1);
    idle(66 * PERIOD);
    measure("fade", 0, 0, 0);
    fb = '{8'h03, 8'h01};
    send_frame(1'b1);

    // Restarted frame: both duties commit together with the final rising pulse.
    fb = '{8'h00, 8'h20};
    send_frame(1'b0);
    idle(PERIOD + 7);
    fb = '{8'h01, 8'h30};
    send_frame(1'b1);
    settle();
    measure("restart", 32, 48, 0);

    // Random frames, gaps and stray strobes.
    for (int f = 0; f < 8; f++) begin
      int n;
      fb.delete();
      fb.push_back(8'($urandom_range(0, NREG)));
      n = $urandom_range(0, 4);
      for (int b = 0; b < n; b++) fb.push_back(8'($urandom));
      send_frame($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 1) == 1) step(1'b0, 1'b1, 8'($urandom), 1'b0);
      idle($urandom_range(0, 300));
    end

    // Known state, then an out-of-range write sets the sticky error.
    fb = '{8'h00, 8'h40, 8'h00, 8'h00, 8'h01, 8'h00};
    send_frame(1'b1);
    fb = '{8'h04, 8'h01, 8'h00, 8'h55};
    send_frame(1'b1);
    idle(4);
    check("err_set", 32'(frame_err), 32'd1);
    fb = '{8'h02};
    send_frame(1'b1);
    idle(4);
    check("err_addr_only", 32'(frame_err), 32'd1);
    fb = '{8'h00, 8'h40};
    send_frame(1'b1);
    idle(4);
    check("err_clear", 32'(frame_err), 32'd0);
    settle();
    measure("pre_rst", 64, 0, 0);

    // Reset in the middle of a frame.
    fb = '{8'h00, 8'h77};
    send_frame(1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_pwm", 32'(pwm_out), 32'd0);
    check("async_rst_err", 32'(frame_err), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    reset_model();
    step(1'b0, 1'b0, 8'd0, 1'b1);
    settle();
    measure("post_rst", 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
